// File: rtl/log_mover.sv
// Scrolling log-lane controller: five lanes of three logs each, every lane moving
// one pixel per (L+1) frames in a fixed direction, with wrap-around, pause and restart.
module log_mover #(
   parameter int NUM_OF_LOGS = 15,
   parameter int X_WRAP      = 680,
   parameter int LANE_Y0     = 80,
   parameter int LANE_PITCH  = 20
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         startOfFrame,
   input  logic                         pause,
   input  logic                         restart,
   output logic [NUM_OF_LOGS-1:0][10:0] ObjectStartX,
   output logic [NUM_OF_LOGS-1:0][10:0] ObjectStartY,
   output logic [4:0]                   lane_step,
   output logic [4:0]                   lane_dir
);

   localparam int          NUM_LANES = 5;
   localparam int          SLOTS     = 3;
   localparam int          SLOT_GAP  = 226;
   localparam int          LANE_SKEW = 40;
   localparam logic [4:0]  DIR       = 5'b10101;
   localparam logic [10:0] X_LAST    = 11'(X_WRAP - 1);

   typedef enum logic {
      RUN    = 1'b0,
      PAUSED = 1'b1
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 frame_go;
   logic [NUM_LANES-1:0] lane_hit;
   logic [2:0]           cnt [NUM_LANES];

   assign lane_dir = DIR;

   // One-pixel move with explicit wrap at both ends of 0..X_WRAP-1.
   function automatic logic [10:0] step_x(input logic [10:0] x, input logic right);
      if (right)
         return (x == X_LAST) ? 11'd0 : x + 11'd1;
      else
         return (x == 11'd0) ? X_LAST : x - 11'd1;
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET)
         state <= RUN;
      else
         state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_next = state;
      frame_go   = 1'b0;
      lane_hit   = '0;

      if (restart)
         state_next = RUN;
      else if (pause)
         state_next = PAUSED;
      else
         state_next = RUN;

      // A frame counts only when already running and nothing of higher priority is asserted.
      frame_go = (state == RUN) && startOfFrame && !pause && !restart;
      for (int l = 0; l < NUM_LANES; l++)
         lane_hit[l] = frame_go && (cnt[l] == 3'(l));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET || restart) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            cnt[l] <= '0;
            for (int j = 0; j < SLOTS; j++) begin
               ObjectStartX[SLOTS*l + j] <= 11'(j*SLOT_GAP + l*LANE_SKEW);
               ObjectStartY[SLOTS*l + j] <= 11'(LANE_Y0 + l*LANE_PITCH);
            end
         end
         lane_step <= '0;
      end else begin
         lane_step <= lane_hit;
         if (frame_go) begin
            for (int l = 0; l < NUM_LANES; l++) begin
               if (lane_hit[l]) begin
                  cnt[l] <= '0;
                  for (int j = 0; j < SLOTS; j++)
                     ObjectStartX[SLOTS*l + j] <= step_x(ObjectStartX[SLOTS*l + j], DIR[l]);
               end else begin
                  cnt[l] <= cnt[l] + 3'd1;
               end
            end
         end
      end
   end

endmodule
